// File: rtl/mesi_isc_breq_arbiter_if.sv
// Bus bundle between the per-CPU request FIFOs, the arbiter and the broadcast FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface mesi_isc_breq_arbiter_if #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5
);
    logic [3:0]                    fifo_status_empty_array_i;
    logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i;
    logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i;
    logic [3:0]                    fifo_rd_array_o;
    logic                          broad_fifo_full_i;
    logic                          broad_fifo_wr_o;
    logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o;
    logic [ADDR_WIDTH-1:0]         broad_addr_o;
    logic [1:0]                    broad_cpu_id_o;
    logic [BROAD_ID_WIDTH-1:0]     broad_id_o;

    modport master (
        input  fifo_status_empty_array_i, breq_type_array_i, breq_addr_array_i, broad_fifo_full_i,
        output fifo_rd_array_o, broad_fifo_wr_o, broad_type_o, broad_addr_o, broad_cpu_id_o, broad_id_o
    );

    modport slave (
        output fifo_status_empty_array_i, breq_type_array_i, breq_addr_array_i, broad_fifo_full_i,
        input  fifo_rd_array_o, broad_fifo_wr_o, broad_type_o, broad_addr_o, broad_cpu_id_o, broad_id_o
    );
endinterface

// File: rtl/mesi_isc_breq_arbiter.sv
// Round-robin arbiter moving CPU bus requests into the broadcast FIFO,
// tagging each with its CPU id and a rolling broadcast id.
module mesi_isc_breq_arbiter #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    mesi_isc_breq_arbiter_if.master bus
);
    localparam int unsigned N_CPU = 4;
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_NOP = '0;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, PUSH = 2'd2} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [1:0]                  win_q, win_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
    logic [3:0]                  fifo_rd_q, fifo_rd_d;
    logic                        broad_wr_q, broad_wr_d;
    logic [BROAD_TYPE_WIDTH-1:0] broad_type_q, broad_type_d;
    logic [ADDR_WIDTH-1:0]       broad_addr_q, broad_addr_d;
    logic [1:0]                  broad_cpu_id_q, broad_cpu_id_d;
    logic [BROAD_ID_WIDTH-1:0]   broad_id_q, broad_id_d;

    logic [BROAD_TYPE_WIDTH-1:0] head_type_c [N_CPU];
    logic [ADDR_WIDTH-1:0]       head_addr_c [N_CPU];
    logic                        win_found_c;
    logic [1:0]                  win_idx_c;
    logic [1:0]                  cand_c;
    logic                        go_c;

    // Unpack the per-CPU show-ahead heads
    always_comb begin
        for (int unsigned k = 0; k < N_CPU; k++) begin
            head_type_c[k] = bus.breq_type_array_i[k*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
            head_addr_c[k] = bus.breq_addr_array_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // First non-empty CPU starting at the round-robin pointer
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = rr_ptr_q;
        cand_c      = rr_ptr_q;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            cand_c = rr_ptr_q + 2'(i);
            if (!win_found_c && !bus.fifo_status_empty_array_i[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Full is only looked at here; this block is the sole writer so the slot stays free until PUSH
    assign go_c = (state_q == IDLE) && win_found_c && !bus.broad_fifo_full_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_c) state_d = GRANT;
            GRANT:   state_d = (type_q == TYPE_NOP) ? IDLE : PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        win_d          = win_q;
        type_d         = type_q;
        addr_d         = addr_q;
        id_cnt_d       = id_cnt_q;
        fifo_rd_d      = '0;
        broad_wr_d     = 1'b0;
        broad_type_d   = broad_type_q;
        broad_addr_d   = broad_addr_q;
        broad_cpu_id_d = broad_cpu_id_q;
        broad_id_d     = broad_id_q;
        case (state_q)
            IDLE: begin
                if (go_c) begin
                    win_d     = win_idx_c;
                    type_d    = head_type_c[win_idx_c];
                    addr_d    = head_addr_c[win_idx_c];
                    fifo_rd_d = 4'b0001 << win_idx_c;
                end
            end
            GRANT: begin
                rr_ptr_d = win_q + 2'd1;
                // NOP entries are popped and silently dropped
                if (type_q != TYPE_NOP) begin
                    broad_wr_d     = 1'b1;
                    broad_type_d   = type_q;
                    broad_addr_d   = addr_q;
                    broad_cpu_id_d = win_q;
                    broad_id_d     = id_cnt_q;
                end
            end
            PUSH: id_cnt_d = id_cnt_q + BROAD_ID_WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            win_q          <= '0;
            type_q         <= '0;
            addr_q         <= '0;
            id_cnt_q       <= '0;
            fifo_rd_q      <= '0;
            broad_wr_q     <= 1'b0;
            broad_type_q   <= '0;
            broad_addr_q   <= '0;
            broad_cpu_id_q <= '0;
            broad_id_q     <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            win_q          <= win_d;
            type_q         <= type_d;
            addr_q         <= addr_d;
            id_cnt_q       <= id_cnt_d;
            fifo_rd_q      <= fifo_rd_d;
            broad_wr_q     <= broad_wr_d;
            broad_type_q   <= broad_type_d;
            broad_addr_q   <= broad_addr_d;
            broad_cpu_id_q <= broad_cpu_id_d;
            broad_id_q     <= broad_id_d;
        end
    end

    assign bus.fifo_rd_array_o = fifo_rd_q;
    assign bus.broad_fifo_wr_o = broad_wr_q;
    assign bus.broad_type_o    = broad_type_q;
    assign bus.broad_addr_o    = broad_addr_q;
    assign bus.broad_cpu_id_o  = broad_cpu_id_q;
    assign bus.broad_id_o      = broad_id_q;
endmodule

// File: tb/tb_mesi_isc_breq_arbiter.sv
// Bench for mesi_isc_breq_arbiter: queue-modelled CPU FIFOs, a cycle-scheduled
// reference of pops and writes, directed scenarios and a randomized soak.
module tb_mesi_isc_breq_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned TW = 2;
    localparam int unsigned IW = 5;
    localparam logic [1:0] T_NOP = 2'd0;
    localparam logic [1:0] T_WR  = 2'd1;
    localparam logic [1:0] T_RD  = 2'd2;

    typedef struct packed {logic [1:0] t; logic [31:0] a;} ent_t;
    typedef struct packed {logic [1:0] t; logic [31:0] a; logic [1:0] c; logic [4:0] i;} pay_t;

    logic clk;
    logic rst;

    mesi_isc_breq_arbiter_if #(.ADDR_WIDTH(AW), .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW)) bus ();

    mesi_isc_breq_arbiter #(.ADDR_WIDTH(AW), .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int cyc;
    int next_dec;
    int rr;
    int id_cnt;
    int push_pct;
    logic rst_drive;
    logic full_drive;

    ent_t fq [4][$];
    logic [3:0] s_rd [4];
    logic       s_wr [4];
    pay_t       s_pay [4];
    pay_t       last;

    logic [3:0]  sn_rd;
    logic        sn_wr;
    logic [1:0]  sn_type;
    logic [31:0] sn_addr;
    logic [1:0]  sn_cpu;
    logic [4:0]  sn_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        rr = 0;
        id_cnt = 0;
        last = '0;
        next_dec = 0;
        for (int k = 0; k < 4; k++) begin
            s_rd[k] = '0;
            s_wr[k] = 1'b0;
            s_pay[k] = '0;
        end
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.t = ($urandom_range(0, 3) == 0) ? T_NOP : (($urandom_range(0, 1) == 0) ? T_WR : T_RD);
        e.a = $urandom;
        return e;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < 4; k++) begin
            if (fq[k].size() > 0) begin
                bus.fifo_status_empty_array_i[k] = 1'b0;
                bus.breq_type_array_i[k*2 +: 2]  = fq[k][0].t;
                bus.breq_addr_array_i[k*32 +: 32] = fq[k][0].a;
            end else begin
                bus.fifo_status_empty_array_i[k] = 1'b1;
                bus.breq_type_array_i[k*2 +: 2]  = 2'($urandom_range(0, 2));
                bus.breq_addr_array_i[k*32 +: 32] = $urandom;
            end
        end
        bus.broad_fifo_full_i = full_drive;
    endtask

    // One clock cycle: check outputs, update FIFOs, drive inputs, let the model arbitrate
    task automatic tick();
        int slot;
        logic [3:0] e_rd;
        logic e_wr;
        @(negedge clk);
        sn_rd = bus.fifo_rd_array_o;
        sn_wr = bus.broad_fifo_wr_o;
        sn_type = bus.broad_type_o;
        sn_addr = bus.broad_addr_o;
        sn_cpu = bus.broad_cpu_id_o;
        sn_id = bus.broad_id_o;
        slot = cyc % 4;
        if (rst) begin
            e_rd = '0;
            e_wr = 1'b0;
        end else begin
            e_rd = s_rd[slot];
            e_wr = s_wr[slot];
            if (e_wr) last = s_pay[slot];
        end
        s_rd[slot] = '0;
        s_wr[slot] = 1'b0;
        chk("fifo_rd", 64'(sn_rd), 64'(e_rd));
        chk("broad_wr", 64'(sn_wr), 64'(e_wr));
        chk("broad_type", 64'(sn_type), 64'(last.t));
        chk("broad_addr", 64'(sn_addr), 64'(last.a));
        chk("broad_cpu_id", 64'(sn_cpu), 64'(last.c));
        chk("broad_id", 64'(sn_id), 64'(last.i));

        for (int k = 0; k < 4; k++)
            if (sn_rd[k] && fq[k].size() > 0) fq[k].delete(0);
        for (int k = 0; k < 4; k++)
            if (fq[k].size() < 4 && $urandom_range(0, 99) < push_pct) fq[k].push_back(rand_ent());

        if (rst_drive && !rst) begin
            rst = 1'b1;
            model_reset();
            #1;
            chk("rst_imm_rd", 64'(bus.fifo_rd_array_o), 64'h0);
            chk("rst_imm_wr", 64'(bus.broad_fifo_wr_o), 64'h0);
            chk("rst_imm_type", 64'(bus.broad_type_o), 64'h0);
            chk("rst_imm_addr", 64'(bus.broad_addr_o), 64'h0);
            chk("rst_imm_cpu", 64'(bus.broad_cpu_id_o), 64'h0);
            chk("rst_imm_id", 64'(bus.broad_id_o), 64'h0);
        end else begin
            rst = rst_drive;
        end
        if (rst) model_reset();

        drive_inputs();

        if (!rst && cyc >= next_dec && !full_drive) begin
            int win;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (rr + k) % 4;
                if (win < 0 && fq[c].size() > 0) win = c;
            end
            if (win >= 0) begin
                ent_t e;
                e = fq[win][0];
                s_rd[(cyc + 1) % 4] = 4'(1 << win);
                rr = (win + 1) % 4;
                if (e.t != T_NOP) begin
                    s_wr[(cyc + 2) % 4] = 1'b1;
                    s_pay[(cyc + 2) % 4] = '{t: e.t, a: e.a, c: 2'(win), i: 5'(id_cnt)};
                    id_cnt = (id_cnt + 1) % 32;
                    next_dec = cyc + 3;
                end else begin
                    next_dec = cyc + 2;
                end
            end
        end
        cyc++;
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < 4; k++) fq[k].delete();
    endtask

    initial begin
        int wl_cpu[$];
        int wl_id[$];
        int wl_cyc[$];
        int nw;
        bit found;
        ent_t e;

        vectors = 0;
        miscompares = 0;
        cyc = 0;
        push_pct = 0;
        rst = 1'b1;
        rst_drive = 1'b1;
        full_drive = 1'b0;
        model_reset();
        bus.fifo_status_empty_array_i = 4'hF;
        bus.breq_type_array_i = '0;
        bus.breq_addr_array_i = '0;
        bus.broad_fifo_full_i = 1'b0;

        repeat (3) tick();
        chk("lit_rst_rd", 64'(sn_rd), 64'h0);
        chk("lit_rst_id", 64'(sn_id), 64'h0);

        // Single request from CPU 2
        rst_drive = 1'b0;
        fq[2].push_back('{t: T_RD, a: 32'h0000_1000});
        tick();
        tick();
        chk("lit_single_rd", 64'(sn_rd), 64'h4);
        chk("lit_single_wr0", 64'(sn_wr), 64'h0);
        tick();
        chk("lit_single_wr", 64'(sn_wr), 64'h1);
        chk("lit_single_type", 64'(sn_type), 64'h2);
        chk("lit_single_addr", 64'(sn_addr), 64'h1000);
        chk("lit_single_cpu", 64'(sn_cpu), 64'h2);
        chk("lit_single_id", 64'(sn_id), 64'h0);
        chk("lit_single_rd0", 64'(sn_rd), 64'h0);
        tick();

        // All four CPUs busy, from a fresh reset
        rst_drive = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 4; n++) begin
                e.t = (n % 2 == 0) ? T_RD : T_WR;
                e.a = 32'((k << 8) | n);
                fq[k].push_back(e);
            end
        rst_drive = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (sn_wr) begin
                wl_cpu.push_back(int'(sn_cpu));
                wl_id.push_back(int'(sn_id));
                wl_cyc.push_back(cyc);
            end
        end
        chk("lit_all4_count", 64'(wl_cpu.size()), 64'd5);
        for (int i = 0; i < wl_cpu.size(); i++) begin
            chk("lit_all4_cpu", 64'(wl_cpu[i]), 64'(i % 4));
            chk("lit_all4_id", 64'(wl_id[i]), 64'(i));
            if (i > 0) chk("lit_all4_gap", 64'(wl_cyc[i] - wl_cyc[i-1]), 64'd3);
        end

        // Reset in the middle of a PUSH, then the first grant restarts at CPU 0
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            tick();
            if (sn_rd != 4'b0000) found = 1'b1;
        end
        if (!found) chk("grant_timeout", 64'h0, 64'h1);
        rst_drive = 1'b1;
        tick();
        chk("lit_push_before_rst", 64'(sn_wr), 64'h1);
        rst_drive = 1'b0;
        tick();
        tick();
        chk("lit_rst_first_grant", 64'(sn_rd), 64'h1);

        // Broadcast FIFO full holds everything off
        fq[1].push_back('{t: T_RD, a: 32'h0000_5555});
        full_drive = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("lit_full_rd", 64'(sn_rd), 64'h0);
            chk("lit_full_wr", 64'(sn_wr), 64'h0);
        end
        full_drive = 1'b0;
        tick();
        tick();
        chk("lit_full_pop", 64'(sn_rd), 64'h2);
        tick();
        chk("lit_full_wr1", 64'(sn_wr), 64'h1);
        chk("lit_full_cpu", 64'(sn_cpu), 64'h1);
        chk("lit_full_id", 64'(sn_id), 64'h1);
        tick();

        // NOP drop keeps the id unchanged
        rst_drive = 1'b1;
        tick();
        clear_fifos();
        tick();
        rst_drive = 1'b0;
        fq[1].push_back('{t: T_NOP, a: 32'h0000_0bad});
        fq[1].push_back('{t: T_RD, a: 32'habcd_0000});
        tick();
        tick();
        chk("lit_nop_pop", 64'(sn_rd), 64'h2);
        chk("lit_nop_wr", 64'(sn_wr), 64'h0);
        tick();
        chk("lit_nop_nowr", 64'(sn_wr), 64'h0);
        tick();
        chk("lit_nop_pop2", 64'(sn_rd), 64'h2);
        tick();
        chk("lit_nop_wr2", 64'(sn_wr), 64'h1);
        chk("lit_nop_id", 64'(sn_id), 64'h0);
        chk("lit_nop_addr", 64'(sn_addr), 64'habcd_0000);

        // Broadcast id wrap with 33 requests from CPU 3
        rst_drive = 1'b1;
        tick();
        clear_fifos();
        for (int n = 0; n < 33; n++) fq[3].push_back('{t: T_RD, a: 32'(n)});
        tick();
        rst_drive = 1'b0;
        nw = 0;
        for (int n = 0; n < 120; n++) begin
            tick();
            if (sn_rd != 4'b0000) chk("lit_wrap_rd", 64'(sn_rd), 64'h8);
            if (sn_wr) begin
                chk("lit_wrap_id", 64'(sn_id), 64'(nw % 32));
                nw++;
            end
        end
        chk("lit_wrap_count", 64'(nw), 64'd33);

        // Randomized soak with random full and occasional resets
        push_pct = 30;
        for (int n = 0; n < 2000; n++) begin
            full_drive = ($urandom_range(0, 99) < 25);
            rst_drive = ($urandom_range(0, 999) < 5);
            tick();
        end
        rst_drive = 1'b0;
        full_drive = 1'b0;
        push_pct = 0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mesi_isc_breq_arbiter.md
# mesi_isc_breq_arbiter

Round-robin arbiter sitting between the four per-CPU bus-request FIFOs and the single broadcast FIFO of the MESI intersystem coherence block. It selects one non-empty CPU request FIFO, pops its head entry, tags the entry with the originating CPU id and a rolling broadcast id, and writes it into the broadcast FIFO. The broadcast controller later drains that FIFO. This block is the only writer of the broadcast FIFO.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- BROAD_TYPE_WIDTH, 2, request type width (NOP=0, WR=1, RD=2; 3 is never driven by the CPU FIFOs)
- BROAD_ID_WIDTH, 5, broadcast id width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_status_empty_array_i  in  4  per-CPU request FIFO empty; bit k = CPU k
- breq_type_array_i  in  4*BROAD_TYPE_WIDTH  show-ahead head type; slice k = CPU k
- breq_addr_array_i  in  4*ADDR_WIDTH  show-ahead head address; slice k = CPU k
- fifo_rd_array_o  out  4  one-hot pop strobe to the CPU request FIFOs
- broad_fifo_full_i  in  1  broadcast FIFO full
- broad_fifo_wr_o  out  1  broadcast FIFO write strobe
- broad_type_o  out  BROAD_TYPE_WIDTH  type written
- broad_addr_o  out  ADDR_WIDTH  address written
- broad_cpu_id_o  out  2  originating CPU
- broad_id_o  out  BROAD_ID_WIDTH  broadcast id written

## Operation
- The FSM has three states: IDLE, GRANT and PUSH. All outputs are registered.
- In IDLE, the arbiter checks for a request when at least one fifo_status_empty_array_i bit is 0 and broad_fifo_full_i is 0.
  - The winner is the first non-empty CPU in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
  - On that edge the block registers the winner's head type and address and the winner's index. The next state is GRANT.
- GRANT lasts one cycle.
  - fifo_rd_array_o is one-hot at the winner for exactly this cycle.
  - rr_ptr is set to winner+1 mod 4.
  - If the captured type is NOP, the next state is IDLE: the entry is dropped, no write is made and the id is unchanged. Otherwise the next state is PUSH.
- PUSH lasts one cycle.
  - broad_fifo_wr_o = 1.
  - broad_type_o, broad_addr_o, broad_cpu_id_o and broad_id_o carry the entry.
  - On exit, the broadcast id counter increments and the next state is IDLE.
- Full handling:
  - broad_fifo_full_i is sampled only in IDLE.
  - Because this block is the only writer, a slot that is free at decision time is guaranteed free at PUSH. PUSH ignores full.
- The broadcast id counter is BROAD_ID_WIDTH bits and wraps from 2^BROAD_ID_WIDTH-1 to 0.
- broad_type_o, broad_addr_o, broad_cpu_id_o and broad_id_o hold their last written values outside PUSH. They are meaningful only when broad_fifo_wr_o is 1.
- Empty bits and head data are ignored outside IDLE. The empty status updated by a pop is therefore consulted only on the next IDLE cycle.

## Timing
- Reset values (asynchronous on rst=1):
  - state = IDLE, rr_ptr = 0, id counter = 0.
  - fifo_rd_array_o = 0, broad_fifo_wr_o = 0.
  - broad_type_o = 0, broad_addr_o = 0, broad_cpu_id_o = 0, broad_id_o = 0.
- Latency, with cycle 0 being an IDLE cycle where the request is visible and the broadcast FIFO is not full:
  - pop in cycle 1;
  - broadcast write in cycle 2;
  - next arbitration decision at the end of cycle 3.
- Throughput is one broadcast per 3 cycles and one NOP drop per 2 cycles.
- At most one fifo_rd_array_o bit is high in any cycle. fifo_rd_array_o and broad_fifo_wr_o are never high in the same cycle.
- Reset asserted mid-operation:
  - An entry popped in GRANT but not yet written is lost.
  - No write is issued after reset releases until a new arbitration.
- Simultaneous requests from all CPUs are served strictly in rotation. No CPU waits more than 3 other grants.

## Test plan
- **Reset:** assert rst mid-PUSH.
  - All outputs go to 0 immediately.
  - After release, the first grant with all FIFOs non-empty goes to CPU 0.
- **Single request:** fifo_status_empty_array_i=4'b1011, CPU 2 head RD, addr 0x0000_1000.
  - Next cycle: fifo_rd_array_o=4'b0100.
  - Cycle after: broad_fifo_wr_o=1, type 2, addr 0x0000_1000, cpu_id 2, id 0.
- **All four CPUs non-empty for 15 cycles:**
  - Writes come from CPUs 0, 1, 2, 3, 0 with ids 0, 1, 2, 3, 4.
  - Writes are spaced 3 cycles apart.
- **Broadcast FIFO full:** requests pending with broad_fifo_full_i=1 for 10 cycles.
  - No pop and no write during those cycles.
  - Full falls at cycle t: pop at t+1, write at t+2.
- **NOP entry:** CPU 1 head type NOP.
  - Pop 4'b0010, no broad_fifo_wr_o.
  - The next real request from CPU 1 carries the unchanged id.
- **Id wrap:** 33 consecutive RD requests from CPU 3.
  - broad_id_o runs 0..31 and then 0.
  - fifo_rd_array_o only ever equals 4'b1000.
